// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES decryption round controller: one inverse round per clock,
// round keys fetched by index from an external store, valid/ready on both sides.
module aes_inv_cipher_ctrl #(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam int NR = NK + 6;
    localparam logic [3:0] NR_IDX = 4'(NR);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_inv_cipher_ctrl: NK must be 4, 6 or 8");
    end

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [127:0]  st_q, st_d;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return INV_SBOX_TAB[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte r+4c of the state sits at bits [127-8*(r+4c) -: 8].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        for (int i = 0; i < 4; i++) begin
            x2 = xtime(a[i]);
            x4 = xtime(x2);
            x8 = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    // State, round counter and cipher state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    // Next-state, round datapath and handshake/key-index decode from the registered state.
    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = NR_IDX;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = in_block ^ rk_data;
                    rnd_d   = NR_IDX - 4'd1;
                    state_d = (NR == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                rk_idx = rnd_q;
                st_d   = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_data);
                if (rnd_q <= 4'd1) begin
                    state_d = FINAL;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            FINAL: begin
                rk_idx  = 4'd0;
                st_d    = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_data;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_block = st_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl: an AES-128 and an AES-256 instance fed from
// a bench-side key-expansion model; a forward-cipher model supplies extra ciphertexts.
module tb_aes_inv_cipher_ctrl;

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [127:0] in_block;
    logic         out_ready;
    bit           sel;

    logic         in_ready4, out_valid4, busy4;
    logic         in_ready8, out_valid8, busy8;
    logic [3:0]   rk_idx4, rk_idx8;
    logic [127:0] rk_data4, rk_data8, out_block4, out_block8;
    logic [127:0] rk_tab4 [0:15];
    logic [127:0] rk_tab8 [0:15];

    logic         cur_in_ready, cur_out_valid, cur_busy;
    logic [3:0]   cur_rk_idx;
    logic [127:0] cur_out_block;
    int           cur_nr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rk_data4 = rk_tab4[rk_idx4];
    assign rk_data8 = rk_tab8[rk_idx8];

    assign cur_in_ready  = sel ? in_ready8  : in_ready4;
    assign cur_out_valid = sel ? out_valid8 : out_valid4;
    assign cur_busy      = sel ? busy8      : busy4;
    assign cur_rk_idx    = sel ? rk_idx8    : rk_idx4;
    assign cur_out_block = sel ? out_block8 : out_block4;
    assign cur_nr        = sel ? 14 : 10;

    aes_inv_cipher_ctrl #(.NK(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid & ~sel), .in_ready(in_ready4), .in_block(in_block),
        .rk_idx(rk_idx4), .rk_data(rk_data4),
        .out_valid(out_valid4), .out_ready(out_ready & ~sel), .out_block(out_block4),
        .busy(busy4)
    );

    aes_inv_cipher_ctrl #(.NK(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid & sel), .in_ready(in_ready8), .in_block(in_block),
        .rk_idx(rk_idx8), .rk_data(rk_data8),
        .out_valid(out_valid8), .out_ready(out_ready & sel), .out_block(out_block8),
        .busy(busy8)
    );

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return SBOX_TAB[idx -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1919:0] r;
        rcon = 8'h01;
        r = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 60; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k < 15; k++) r[1919 - 128*k -: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return r;
    endfunction

    function automatic logic [127:0] encrypt4(input logic [127:0] pt);
        logic [127:0] s, o;
        logic [7:0] a0, a1, a2, a3;
        s = pt ^ rk_tab4[0];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            s = o;
            if (rd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32*c -: 8];
                    a1 = s[119 - 32*c -: 8];
                    a2 = s[111 - 32*c -: 8];
                    a3 = s[103 - 32*c -: 8];
                    o[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
                end
                s = o;
            end
            s = s ^ rk_tab4[rd];
        end
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offers ct in an IDLE cycle; it is accepted at the next rising edge.
    task automatic applyStimulus(input logic [127:0] ct, input string name);
        @(negedge clk);
        checkOutput({name, " in_ready before accept"}, 128'(cur_in_ready), 128'd1);
        checkOutput({name, " rk_idx at accept"}, 128'(cur_rk_idx), 128'(cur_nr));
        in_block = ct;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_block = 128'hdeadbeef_cafef00d_0badc0de_12345678;
    endtask

    // Counts edges after the accept edge until out_valid, checking the rk_idx walk.
    task automatic waitOutput(output int edges, output bit seq_ok);
        edges = 0;
        seq_ok = 1'b1;
        while (!cur_out_valid && edges < 40) begin
            if (int'(cur_rk_idx) != cur_nr - 1 - edges) seq_ok = 1'b0;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic runBlock(input logic [127:0] ct, input logic [127:0] pt, input string name);
        int edges;
        bit seq_ok;
        applyStimulus(ct, name);
        waitOutput(edges, seq_ok);
        checkOutput({name, " latency"}, 128'(edges), 128'(cur_nr));
        checkOutput({name, " rk_idx sequence"}, 128'(seq_ok), 128'd1);
        checkOutput({name, " plaintext"}, cur_out_block, pt);
        checkOutput({name, " rk_idx in done"}, 128'(cur_rk_idx), 128'(cur_nr));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " out_valid after handshake"}, 128'(cur_out_valid), 128'd0);
        checkOutput({name, " in_ready after handshake"}, 128'(cur_in_ready), 128'd1);
    endtask

    typedef struct {
        string        name;
        logic [127:0] ct;
        logic [127:0] pt;
        bit           nk8;
    } vec_t;

    initial begin
        vec_t vecs [5];
        logic [1919:0] ks;
        logic [127:0] ct_zero;
        logic [127:0] got [2];
        int acc_at [2];
        int accepts, outs, edges;
        bit seq_ok;

        reset = 1'b1;
        in_valid = 1'b0;
        in_block = '0;
        out_ready = 1'b0;
        sel = 1'b0;

        ks = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        for (int k = 0; k < 16; k++) rk_tab4[k] = (k < 11) ? ks[1919 - 128*k -: 128] : '0;
        ks = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        for (int k = 0; k < 16; k++) rk_tab8[k] = (k < 15) ? ks[1919 - 128*k -: 128] : '0;
        ct_zero = encrypt4('0);

        vecs[0] = '{"C.1 vector", C1_CT, FIPS_PT, 1'b0};
        vecs[1] = '{"zero plaintext", ct_zero, 128'h0, 1'b0};
        vecs[2] = '{"ones plaintext", encrypt4({128{1'b1}}), {128{1'b1}}, 1'b0};
        vecs[3] = '{"mixed plaintext", encrypt4(128'h0123456789abcdeffedcba9876543210),
                    128'h0123456789abcdeffedcba9876543210, 1'b0};
        vecs[4] = '{"C.3 vector", C3_CT, FIPS_PT, 1'b1};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            checkOutput("reset in_ready", 128'(cur_in_ready), 128'd1);
            checkOutput("reset out_valid", 128'(cur_out_valid), 128'd0);
            checkOutput("reset busy", 128'(cur_busy), 128'd0);
            checkOutput("reset rk_idx", 128'(cur_rk_idx), 128'(cur_nr));
            checkOutput("reset out_block", cur_out_block, 128'h0);
        end
        sel = 1'b0;
        reset = 1'b0;

        $display("[TB] table-driven vectors");
        for (int v = 0; v < 5; v++) begin
            sel = vecs[v].nk8;
            runBlock(vecs[v].ct, vecs[v].pt, vecs[v].name);
        end
        sel = 1'b0;

        $display("[TB] output backpressure");
        applyStimulus(C1_CT, "backpressure");
        waitOutput(edges, seq_ok);
        checkOutput("backpressure latency", 128'(edges), 128'd10);
        in_block = ct_zero;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checkOutput("backpressure out_valid held", 128'(cur_out_valid), 128'd1);
            checkOutput("backpressure in_ready low", 128'(cur_in_ready), 128'd0);
            checkOutput("backpressure out_block stable", cur_out_block, FIPS_PT);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("backpressure in_ready after release", 128'(cur_in_ready), 128'd1);
        checkOutput("backpressure busy after release", 128'(cur_busy), 128'd0);
        checkOutput("backpressure second block not taken", cur_out_block, FIPS_PT);

        $display("[TB] back-to-back blocks");
        @(negedge clk);
        in_block = C1_CT;
        in_valid = 1'b1;
        out_ready = 1'b1;
        accepts = 0;
        outs = 0;
        for (int n = 0; n < 60 && outs < 2; n++) begin
            if (in_valid && cur_in_ready && accepts < 2) begin
                acc_at[accepts] = n;
                accepts++;
            end
            if (cur_out_valid) begin
                got[outs] = cur_out_block;
                outs++;
            end
            @(negedge clk);
            if (accepts == 1) in_block = ct_zero;
            if (accepts == 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b accept count", 128'(accepts), 128'd2);
        checkOutput("b2b output count", 128'(outs), 128'd2);
        if (accepts == 2) checkOutput("b2b accept spacing", 128'(acc_at[1] - acc_at[0]), 128'd12);
        if (outs == 2) begin
            checkOutput("b2b first plaintext", got[0], FIPS_PT);
            checkOutput("b2b second plaintext", got[1], 128'h0);
        end

        $display("[TB] reset mid-operation");
        applyStimulus(C1_CT, "midreset");
        repeat (4) @(negedge clk);
        checkOutput("midreset at round 5", 128'(cur_rk_idx), 128'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset out_valid", 128'(cur_out_valid), 128'd0);
        checkOutput("midreset busy", 128'(cur_busy), 128'd0);
        checkOutput("midreset in_ready", 128'(cur_in_ready), 128'd1);
        checkOutput("midreset rk_idx", 128'(cur_rk_idx), 128'd10);
        checkOutput("midreset st cleared", cur_out_block, 128'h0);
        runBlock(C1_CT, FIPS_PT, "after midreset");

        $display("[TB] reset in done");
        applyStimulus(C1_CT, "donereset");
        waitOutput(edges, seq_ok);
        checkOutput("donereset out_valid before reset", 128'(cur_out_valid), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("donereset out_valid", 128'(cur_out_valid), 128'd0);
        checkOutput("donereset in_ready", 128'(cur_in_ready), 128'd1);
        checkOutput("donereset busy", 128'(cur_busy), 128'd0);
        checkOutput("donereset out_block", cur_out_block, 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES decryption round controller. It accepts one 128-bit ciphertext block over a valid/ready handshake and computes one inverse round per clock through the team's combinational InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns units. It requests round keys by index from an external round-key store and returns the plaintext over a second valid/ready handshake. It sits between the key-expansion block and the decryption top level.

## Interface
- NK, 4, key length in 32-bit words (4/6/8 = AES-128/192/256); NR = NK+6 rounds; any other value is an elaboration error
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext block offered
- in_ready  out  1  block accepted when in_valid && in_ready at an edge
- in_block  in  128  ciphertext, byte 0 in bits [127:120] (column-major, same state layout as the round units)
- rk_idx  out  4  round-key index requested this cycle
- rk_data  in  128  round key for rk_idx, combinational, same cycle
- out_valid  out  1  plaintext available
- out_ready  in  1  plaintext consumed when out_valid && out_ready at an edge
- out_block  out  128  plaintext
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE; 4-bit round counter rnd; 128-bit state register st.
- IDLE: in_ready=1, rk_idx=NR. On accept: st <= in_block ^ rk_data; rnd <= NR-1; go to ROUND (go to FINAL if NR-1 = 0, which is unreachable for legal NK).
- ROUND: rk_idx=rnd; st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_data). This is the FIPS-197 inverse-cipher order, with AddRoundKey before InvMixColumns. If rnd==1, go to FINAL; else rnd <= rnd-1.
- FINAL: rk_idx=0; st <= InvSubBytes(InvShiftRows(st)) ^ rk_data, with no InvMixColumns; go to DONE.
- DONE: out_valid=1, out_block=st, rk_idx=NR. On out_ready, go to IDLE. If out_ready stays low, st and out_block hold indefinitely.
- in_ready is high only in IDLE. in_block is ignored in every other state, and there is no overlap between blocks.
- out_block is driven from st in all states. It is qualified only by out_valid.
- rnd never wraps: it decrements only in ROUND and only while rnd ≥ 2.

## Timing
- Reset values: state IDLE, st=0, rnd=0; in_ready=1 in the cycle after the reset edge; out_valid=0, busy=0, rk_idx=NR, out_block=0.
- Reset asserted in any state, including mid-round or in DONE with a pending output: the next edge returns to IDLE with all of the above values and discards the block. Reset has priority over both handshakes.
- Latency: an accept at edge E0 raises out_valid after edge E(NR). That is 10/12/14 cycles for NK=4/6/8.
- Throughput with out_ready tied high: one block per NR+2 cycles (accept, NR-1 rounds, final, done).
- rk_idx is a registered-state decode: stable for the whole cycle, glitch-free relative to clk. rk_data must settle within the same cycle.
- Sequence of rk_idx per block: NR (IDLE at accept), NR-1 … 1, 0, then NR.
- out_valid and busy deassert on the edge that completes the output handshake. in_ready rises in the same cycle.

## Test plan
- FIPS-197 C.1 (NK=4): key 000102…0f via key-expansion model, in_block 69c4e0d86a7b0430d8cdb78070b4c55a → out_block 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept, rk_idx sequence 10,9,…,0.
- FIPS-197 C.3 (NK=8): key 000102…1f, in_block 8ea2b7ca516745bfeafc49904b496089 → 00112233445566778899aabbccddeeff after 14 cycles.
- Output backpressure: hold out_ready low 5 cycles after out_valid → out_block stable, in_ready=0, and a second in_valid is not accepted. After out_ready=1, in_ready=1 on the next cycle.
- Back-to-back: two blocks (C.1 ciphertext, then ciphertext of all-zero plaintext under the same key) with in_valid and out_ready held high → both plaintexts correct, accepts exactly 12 cycles apart.
- Reset mid-operation: assert reset at round 5 of a C.1 decrypt → next cycle IDLE, out_valid=0, busy=0, st=0. A fresh C.1 decrypt after reset produces the correct plaintext.
- Reset in DONE with out_ready=0 → out_valid drops, no handshake completes, in_ready=1.
